// File: rtl/wb_calram_reader_if.sv
// Bus bundle for wb_calram_reader: the WISHBONE read master port toward the calram
// slave, plus the valid/ready output stream toward the packetizer/DMA.
// Modports: master = reader side (drives cyc/stb/adr and the stream), slave = bus/sink side.
interface wb_calram_reader_if;
  // WISHBONE master side
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [18:0] wbm_adr_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  // output stream
  logic [31:0] dat_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    output dat_o, valid_o, last_o,
    input  ready_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i,
    input  dat_o, valid_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/wb_calram_reader.sv
// Purpose: WB read engine streaming a contiguous word run of one calram chunk into a FWFT FIFO.
// Latency: 3 cycles/word with a registered-ack slave; first word on valid_o 1 cycle after its ack.
// Backpressure: ready_i low fills the FIFO; no access is issued unless the FIFO can take its word.
// Ports: clk_i/rst_n_i (sync, active-low); start_i/abort_i/chunk_i/addr_i/count_i run control;
//        busy_o/done_o/err_o status; bus = WB master (cyc/stb/adr/ack/err/rty) + dat/valid/ready/last.
module wb_calram_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [4:0]                chunk_i,
  input  logic [11:0]               addr_i,
  input  logic [12:0]               count_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  wb_calram_reader_if.master        bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [15:0]   TMO_C   = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [4:0]    chunk_q, chunk_d;
  logic [11:0]   addr_q, addr_d;
  logic [12:0]   rem_q, rem_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          abort_q, abort_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:0]   mem_q [FIFO_DEPTH];   // {last, data}

  logic          push, pop, room, fault, ack_ok;
  logic [32:0]   rd_word;

  always_comb begin
    room    = (cnt_q < DEPTH_C);
    pop     = (cnt_q != '0) && bus.ready_i;
    // A simultaneous retry means the slave has not really completed the access.
    ack_ok  = bus.wbm_ack_i && !bus.wbm_rty_i;
    fault   = bus.wbm_err_i || (tmo_q == TMO_C);
    push    = 1'b0;
    state_d = state_q;
    chunk_d = chunk_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    abort_d = abort_q || abort_i;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        // done_q blocks a start so done_o never coincides with an accepted start.
        if (start_i && (cnt_q == '0) && !done_q) begin
          chunk_d = chunk_i;
          addr_d  = addr_i;
          rem_d   = count_i;
          err_d   = 1'b0;
          if (count_i == 13'd0) begin
            done_d = 1'b1;
          end else if (room) begin
            state_d = S_REQ;
            tmo_d   = 16'd1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_REQ: begin
        if (fault) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (ack_ok) begin
          push    = 1'b1;
          addr_d  = addr_q + 12'd1;   // wraps inside the chunk
          rem_d   = rem_q - 13'd1;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_GAP: begin
        // The slave's registered ack from the previous access lands here and is dropped.
        if ((rem_q == '0) || abort_d) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!room) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_REQ;
          tmo_d   = 16'd1;
        end
      end
      S_HOLD: begin
        if (abort_d) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (room) begin
          state_d = S_REQ;
          tmo_d   = 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      chunk_q  <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      abort_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      chunk_q  <= chunk_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      abort_q  <= abort_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {(rem_q == 13'd1), bus.wbm_dat_i};
    end
  end

  assign rd_word       = mem_q[rd_ptr_q];
  assign bus.wbm_cyc_o = (state_q == S_REQ);
  assign bus.wbm_stb_o = (state_q == S_REQ);
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_sel_o = 4'hF;
  assign bus.wbm_adr_o = {chunk_q, addr_q, 2'b00};
  assign bus.valid_o   = (cnt_q != '0);
  assign bus.dat_o     = rd_word[31:0];
  assign bus.last_o    = bus.valid_o && rd_word[32];
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_wb_calram_reader.sv
// Bench for wb_calram_reader: registered-ack WB slave model, stream monitor, and a
// reference that derives the expected address/word list of each run from its parameters.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
`define CHK(tag, obs, exp) \
  begin \
    n_chk++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_wb_calram_reader;
  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic        clk;
  logic        rst_n;
  logic        start, abort;
  logic [4:0]  chunk;
  logic [11:0] addr;
  logic [12:0] count;
  logic        busy, done, err;
  logic        ready_fix, ready_rand, rnd_bit;
  logic        slv_noack;
  int          slv_err_at;
  logic [31:0] seed;

  int n_chk = 0;
  int n_fail = 0;

  wb_calram_reader_if bus();

  wb_calram_reader #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .start_i (start),
    .abort_i (abort),
    .chunk_i (chunk),
    .addr_i  (addr),
    .count_i (count),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] wfun(input logic [18:0] adr);
    return ({13'h0, adr} * 32'h9E3779B1) ^ seed;
  endfunction

  // monitor state
  logic [18:0] adr_q[$];
  logic [32:0] got_q[$];
  int  cyc_n = 0;
  int  done_cnt, done_at, first_req, hi_run, last_hi;
  bit  cyc_prev = 1'b0;
  bit  busy_seen;

  // Registered-ack slave: acks every cycle after seeing cyc&stb, so one stale ack
  // always trails each access.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_err_i <= 1'b0;
      bus.wbm_dat_i <= '0;
    end else begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_err_i <= 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && !slv_noack) begin
        if (slv_err_at != 0 && adr_q.size() == slv_err_at) bus.wbm_err_i <= 1'b1;
        else bus.wbm_ack_i <= 1'b1;
        bus.wbm_dat_i <= wfun(bus.wbm_adr_o);
      end
    end
  end
  assign bus.wbm_rty_i = 1'b0;
  assign bus.ready_i   = ready_rand ? rnd_bit : ready_fix;

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk); #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    if (bus.wbm_cyc_o && !cyc_prev) begin
      adr_q.push_back(bus.wbm_adr_o);
      if (first_req < 0) first_req = cyc_n;
    end
    if (bus.wbm_cyc_o) hi_run++;
    else begin
      if (cyc_prev) last_hi = hi_run;
      hi_run = 0;
    end
    cyc_prev = bus.wbm_cyc_o;
    if (done) begin
      done_cnt++;
      done_at = cyc_n;
    end
    if (busy) busy_seen = 1'b1;
    if (bus.valid_o && bus.ready_i) got_q.push_back({bus.last_o, bus.dat_o});
    if (rst_n) begin
      n_chk++;
      if (bus.wbm_we_o !== 1'b0) begin
        n_fail++;
        $error("FAIL inv we_o observed=%0h expected=0", bus.wbm_we_o);
      end
      n_chk++;
      if (bus.wbm_sel_o !== 4'hF) begin
        n_fail++;
        $error("FAIL inv sel_o observed=%0h expected=f", bus.wbm_sel_o);
      end
      n_chk++;
      if (bus.wbm_stb_o !== bus.wbm_cyc_o) begin
        n_fail++;
        $error("FAIL inv stb_o observed=%0h expected=%0h", bus.wbm_stb_o, bus.wbm_cyc_o);
      end
      n_chk++;
      if ((bus.last_o && !bus.valid_o) !== 1'b0) begin
        n_fail++;
        $error("FAIL inv last_o without valid_o");
      end
      n_chk++;
      if ((bus.wbm_cyc_o && !busy) !== 1'b0) begin
        n_fail++;
        $error("FAIL inv cyc_o without busy_o");
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    adr_q.delete();
    got_q.delete();
    done_cnt = 0; done_at = -1; first_req = -1; last_hi = 0; busy_seen = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] ch, input logic [11:0] a, input logic [12:0] n);
    tick();
    chunk = ch; addr = a; count = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int k = 0;
    while (!(done_cnt > 0 && !busy && !bus.valid_o) && k < 600) begin
      tick();
      k++;
    end
    `CHK($sformatf("%s run_end_in_time", tag), (k < 600), 1'b1)
    repeat (2) tick();
  endtask

  // Expected: access i reads word (a+i) mod 4096 of chunk ch; the first n_words come
  // out in order; last only when the run delivered all cnt words.
  task automatic check_run(input string tag, input logic [4:0] ch, input logic [11:0] a,
                           input int cnt, input int n_words, input int n_acc, input logic exp_err);
    logic [11:0] wa;
    logic        el;
    `CHK($sformatf("%s done_pulses", tag), done_cnt, 1)
    `CHK($sformatf("%s err_o", tag), err, exp_err)
    `CHK($sformatf("%s accesses", tag), adr_q.size(), n_acc)
    for (int i = 0; i < n_acc && i < adr_q.size(); i++) begin
      wa = a + 12'(i);
      `CHK($sformatf("%s adr[%0d]", tag, i), adr_q[i], {ch, wa, 2'b00})
    end
    `CHK($sformatf("%s words", tag), got_q.size(), n_words)
    for (int i = 0; i < n_words && i < got_q.size(); i++) begin
      wa = a + 12'(i);
      el = (n_words == cnt) && (i == cnt - 1);
      `CHK($sformatf("%s word[%0d]", tag, i), got_q[i], {el, wfun({ch, wa, 2'b00})})
    end
  endtask

  initial begin
    logic [4:0]  ch;
    logic [11:0] a;
    int          n, k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chunk = '0; addr = '0; count = '0;
    ready_fix = 1'b1; ready_rand = 1'b0; slv_noack = 1'b0; slv_err_at = 0;
    seed = $urandom;
    clr();
    repeat (3) tick();
    `CHK("reset cyc", bus.wbm_cyc_o, 1'b0)
    `CHK("reset busy", busy, 1'b0)
    `CHK("reset done", done, 1'b0)
    `CHK("reset err", err, 1'b0)
    `CHK("reset valid", bus.valid_o, 1'b0)
    `CHK("reset last", bus.last_o, 1'b0)
    rst_n = 1'b1;
    tick();

    // 1: basic run, full-rate sink
    clr(); seed = $urandom;
    do_start(5'd3, 12'd0, 13'd8);
    wait_end("t1");
    check_run("t1", 5'd3, 12'd0, 8, 8, 8, 1'b0);
    `CHK("t1 req_to_done_cycles", done_at - first_req, 24)

    // 2: address wrap inside the chunk, random sink stalls
    clr(); seed = $urandom; ready_rand = 1'b1;
    ch = 5'($urandom_range(0, 31));
    do_start(ch, 12'd4094, 13'd4);
    wait_end("t2");
    check_run("t2", ch, 12'd4094, 4, 4, 4, 1'b0);
    ready_rand = 1'b0;

    // 3: sink stalled -> exactly DEPTH accesses, then hold; release and drain
    clr(); seed = $urandom; ready_fix = 1'b0;
    ch = 5'($urandom_range(0, 31)); a = 12'($urandom);
    do_start(ch, a, 13'd10);
    repeat (40) tick();
    `CHK("t3 accesses_while_stalled", adr_q.size(), DEPTH)
    `CHK("t3 cyc_in_hold", bus.wbm_cyc_o, 1'b0)
    `CHK("t3 busy_in_hold", busy, 1'b1)
    `CHK("t3 valid_in_hold", bus.valid_o, 1'b1)
    ready_fix = 1'b1;
    wait_end("t3");
    check_run("t3", ch, a, 10, 10, 10, 1'b0);

    // 4a: slave never acks -> timeout
    clr(); seed = $urandom; slv_noack = 1'b1;
    do_start(5'd7, 12'd100, 13'd5);
    wait_end("t4a");
    check_run("t4a", 5'd7, 12'd100, 5, 0, 1, 1'b1);
    `CHK("t4a cyc_high_cycles", last_hi, TMO)
    slv_noack = 1'b0;

    // next accepted start clears err_o
    clr(); seed = $urandom;
    do_start(5'd8, 12'd5, 13'd2);
    `CHK("t4 err_cleared_on_start", err, 1'b0)
    wait_end("t4c");
    check_run("t4c", 5'd8, 12'd5, 2, 2, 2, 1'b0);

    // 4b: err_i on the 3rd access
    clr(); seed = $urandom; slv_err_at = 3;
    do_start(5'd9, 12'd200, 13'd6);
    wait_end("t4b");
    check_run("t4b", 5'd9, 12'd200, 6, 2, 3, 1'b1);
    slv_err_at = 0;

    // 5: ignored start while busy, abort during REQ of word 5 of 20
    clr(); seed = $urandom;
    ch = 5'($urandom_range(0, 31)); a = 12'($urandom);
    do_start(ch, a, 13'd20);
    k = 0;
    while (adr_q.size() < 2 && k < 200) begin tick(); k++; end
    count = 13'd0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (adr_q.size() < 5 && k < 200) begin tick(); k++; end
    `CHK("t5 in_req_of_word5", bus.wbm_cyc_o, 1'b1)
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_end("t5");
    check_run("t5", ch, a, 20, 5, 5, 1'b0);

    // 6: reset mid-access, then a zero-length run
    clr(); seed = $urandom;
    do_start(5'd1, 12'd0, 13'd10);
    k = 0;
    while (!bus.wbm_cyc_o && k < 50) begin tick(); k++; end
    rst_n = 1'b0;
    tick();
    `CHK("t6 cyc_after_reset", bus.wbm_cyc_o, 1'b0)
    `CHK("t6 valid_after_reset", bus.valid_o, 1'b0)
    `CHK("t6 busy_after_reset", busy, 1'b0)
    rst_n = 1'b1;
    tick();
    clr();
    do_start(5'd2, 12'd0, 13'd0);
    `CHK("t6 zero_run_done", done, 1'b1)
    `CHK("t6 zero_run_busy", busy, 1'b0)
    tick();
    `CHK("t6 zero_run_done_pulse_ends", done, 1'b0)
    repeat (3) tick();
    `CHK("t6 zero_run_done_count", done_cnt, 1)
    `CHK("t6 zero_run_accesses", adr_q.size(), 0)
    `CHK("t6 zero_run_never_busy", busy_seen, 1'b0)

    // random runs with random sink stalls
    ready_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      clr(); seed = $urandom;
      ch = 5'($urandom_range(0, 31));
      a  = 12'($urandom_range(4080, 4095));
      n  = $urandom_range(1, 24);
      do_start(ch, a, 13'(n));
      wait_end($sformatf("rnd%0d", r));
      check_run($sformatf("rnd%0d", r), ch, a, n, n, n, 1'b0);
    end
    ready_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
